// File: rtl/fft_twiddle_gen.sv
// Streaming twiddle-factor generator for one radix-2^2 SDF stage pair.
// It tracks the index of each accepted sample, forms the stage exponent
// from the bit-reversed quarter index, and looks up W_N^e in an N-entry
// constant ROM that is built at elaboration. The pipeline latency is
// exactly two cycles, and the outputs are held while no sample is valid.
module fft_twiddle_gen #(
   parameter int WIDTH = 8,
   parameter int LOG2N = 6,
   parameter int STAGE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    in_sof,
   output logic signed [WIDTH-1:0] tw_re,
   output logic signed [WIDTH-1:0] tw_im,
   output logic                    out_valid,
   output logic                    out_last
);

   localparam int  N     = 32'sd1 << LOG2N;
   localparam int  LOG2M = LOG2N - 2 * STAGE;  // log2 of sub-block length M
   localparam int  LOG2Q = LOG2M - 2;          // log2 of quarter length Q
   localparam real PI    = 3.14159265358979323846;

   // Scale to Q1.(WIDTH-1). Round to nearest with ties away from zero,
   // then saturate +1.0 to the largest positive code.
   function automatic logic signed [WIDTH-1:0] quantize(input real x);
      real y;
      int  v;
      int  maxv;
      int  minv;
      maxv = (32'sd1 <<< (WIDTH - 1)) - 32'sd1;
      minv = -(32'sd1 <<< (WIDTH - 1));
      y    = x * real'(32'sd1 <<< (WIDTH - 1));
      if (y >= 0.0) begin
         v = $rtoi(y + 0.5);
      end else begin
         v = -$rtoi(-y + 0.5);
      end
      if (v > maxv) begin
         v = maxv;
      end else if (v < minv) begin
         v = minv;
      end else begin
         v = v;
      end
      return v[WIDTH-1:0];
   endfunction

   function automatic logic signed [WIDTH-1:0] coef_re(input int e);
      return quantize($cos(2.0 * PI * real'(e) / real'(N)));
   endfunction

   function automatic logic signed [WIDTH-1:0] coef_im(input int e);
      return quantize(-$sin(2.0 * PI * real'(e) / real'(N)));
   endfunction

   // Constant coefficient ROM, one entry per exponent value.
   logic signed [WIDTH-1:0] rom_re_s [N];
   logic signed [WIDTH-1:0] rom_im_s [N];

   for (genvar g = 0; g < N; g++) begin : g_rom
      assign rom_re_s[g] = coef_re(g);
      assign rom_im_s[g] = coef_im(g);
   end

   // State and next-state signals.
   logic [LOG2N-1:0]        cnt_q, cnt_d;
   logic [LOG2N-1:0]        e_q, e_d;
   logic                    v1_q, v1_d;
   logic                    last1_q, last1_d;
   logic signed [WIDTH-1:0] tw_re_q, tw_re_d;
   logic signed [WIDTH-1:0] tw_im_q, tw_im_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;

   logic [LOG2N-1:0]        cur_idx_s;
   logic [LOG2M-1:0]        k_s;
   logic [1:0]              q_s;
   logic [1:0]              qrev_s;
   logic [LOG2Q-1:0]        r_s;
   logic [LOG2M-1:0]        prod_s;

   // Index of the current sample. A qualified start of frame forces index 0.
   always_comb begin
      cur_idx_s = cnt_q;
      if (in_valid && in_sof) begin
         cur_idx_s = '0;
      end else begin
         cur_idx_s = cnt_q;
      end
   end

   // Exponent: bit-reversed quarter times the offset within the quarter,
   // then scaled by 4^STAGE.
   always_comb begin
      k_s    = cur_idx_s[LOG2M-1:0];
      q_s    = k_s[LOG2M-1:LOG2Q];
      r_s    = k_s[LOG2Q-1:0];
      qrev_s = 2'd0;
      case (q_s)
         2'd0:    qrev_s = 2'd0;
         2'd1:    qrev_s = 2'd2;
         2'd2:    qrev_s = 2'd1;
         default: qrev_s = 2'd3;
      endcase
      prod_s = LOG2M'(qrev_s) * LOG2M'(r_s);
   end

   // Next state for the counter and both pipeline stages.
   always_comb begin
      cnt_d       = cnt_q;
      e_d         = e_q;
      v1_d        = 1'b0;
      last1_d     = 1'b0;
      tw_re_d     = tw_re_q;
      tw_im_d     = tw_im_q;
      out_valid_d = v1_q;
      out_last_d  = v1_q & last1_q;
      if (in_valid) begin
         cnt_d   = cur_idx_s + LOG2N'(1);
         e_d     = LOG2N'(prod_s) << (2 * STAGE);
         v1_d    = 1'b1;
         last1_d = (cur_idx_s == LOG2N'(N - 1));
      end else begin
         cnt_d   = cnt_q;
         e_d     = e_q;
      end
      if (v1_q) begin
         tw_re_d = rom_re_s[e_q];
         tw_im_d = rom_im_s[e_q];
      end else begin
         tw_re_d = tw_re_q;
         tw_im_d = tw_im_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         e_q         <= '0;
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         tw_re_q     <= '0;
         tw_im_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         e_q         <= e_d;
         v1_q        <= v1_d;
         last1_q     <= last1_d;
         tw_re_q     <= tw_re_d;
         tw_im_q     <= tw_im_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign tw_re     = tw_re_q;
   assign tw_im     = tw_im_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Bench for fft_twiddle_gen: two instances (N=16 stage 0, N=64 stage 1)
// share one input stream and are checked every cycle against a reference
// model that derives each twiddle directly from its sample index.
module tb_fft_twiddle_gen;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic in_sof;
   logic signed [W-1:0] a_re, a_im, b_re, b_im;
   logic a_v, a_l, b_v, b_l;

   int compared   = 0;
   int mismatched = 0;

   fft_twiddle_gen #(.WIDTH(W), .LOG2N(4), .STAGE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .tw_re(a_re), .tw_im(a_im), .out_valid(a_v), .out_last(a_l));

   fft_twiddle_gen #(.WIDTH(W), .LOG2N(6), .STAGE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .tw_re(b_re), .tw_im(b_im), .out_valid(b_v), .out_last(b_l));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state, index 0 = instance A, index 1 = instance B.
   int cfg_l2 [2] = '{4, 6};
   int cfg_st [2] = '{0, 1};
   int m_idx [2];
   int p_v [2], p_l [2], p_re [2], p_im [2];
   int o_v [2], o_l [2], o_re [2], o_im [2];

   function automatic int ref_rnd(input real x);
      real y;
      int  r;
      y = x * 128.0;
      if (y >= 0.0) r = $rtoi($floor(y + 0.5));
      else          r = -$rtoi($floor(-y + 0.5));
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic ref_coef(input int l2, input int st, input int n,
                           output int re, output int im);
      int nn, mm, qq, k, q, r, qb, e;
      real ang;
      nn = 1 << l2;
      mm = nn / (4 ** st);
      qq = mm / 4;
      k  = n % mm;
      q  = k / qq;
      r  = k % qq;
      qb = (q == 1) ? 2 : (q == 2) ? 1 : q;
      e  = qb * r * (4 ** st);
      ang = 2.0 * 3.14159265358979323846 * real'(e) / real'(nn);
      re = ref_rnd($cos(ang));
      im = ref_rnd(-$sin(ang));
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_idx[c] = 0; p_v[c] = 0; p_l[c] = 0; p_re[c] = 0; p_im[c] = 0;
         o_v[c] = 0; o_l[c] = 0; o_re[c] = 0; o_im[c] = 0;
      end
   endtask

   task automatic model_tick(input logic v, input logic s);
      int n, nn;
      for (int c = 0; c < 2; c++) begin
         nn = 1 << cfg_l2[c];
         o_v[c] = p_v[c];
         o_l[c] = p_v[c] & p_l[c];
         if (p_v[c] != 0) begin
            o_re[c] = p_re[c];
            o_im[c] = p_im[c];
         end
         if (v) begin
            n = s ? 0 : m_idx[c];
            p_v[c] = 1;
            p_l[c] = (n == nn - 1) ? 1 : 0;
            ref_coef(cfg_l2[c], cfg_st[c], n, p_re[c], p_im[c]);
            m_idx[c] = (n + 1) % nn;
         end else begin
            p_v[c] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic compare_all();
      chk("A.valid", a_v, o_v[0]);
      chk("A.last",  a_l, o_l[0]);
      chk("A.re",    a_re, o_re[0]);
      chk("A.im",    a_im, o_im[0]);
      chk("B.valid", b_v, o_v[1]);
      chk("B.last",  b_l, o_l[1]);
      chk("B.re",    b_re, o_re[1]);
      chk("B.im",    b_im, o_im[1]);
   endtask

   // Directed check of instance A against a fixed expected value.
   task automatic chk_a(input string tag, input int re, input int im, input int last);
      chk({tag, ".re"}, a_re, re);
      chk({tag, ".im"}, a_im, im);
      chk({tag, ".valid"}, a_v, 1);
      chk({tag, ".last"}, a_l, last);
   endtask

   task automatic step(input logic v, input logic s);
      @(negedge clk);
      in_valid = v;
      in_sof   = s;
      @(posedge clk);
      model_tick(v, s);
      #1;
      compare_all();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      @(posedge clk);
      model_tick(1'b0, 1'b0);
      #1;
      compare_all();
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic async_reset(input string tag);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #1;
      rst_n = 1'b0;
      model_reset();
      #2;
      chk({tag, ".valid"}, a_v, 0);
      chk({tag, ".re"}, a_re, 0);
      chk({tag, ".im"}, a_im, 0);
      compare_all();
      release_reset();
   endtask

   initial begin
      logic v, s;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_sof = 1'b0;
      model_reset();
      #12;
      compare_all();
      release_reset();

      // One full frame starting with in_sof; outputs lag samples by one step.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i == 0);
         if (i >= 1 && i <= 4) chk_a("f1.n0_3", 127, 0, 0);
         if (i == 6)  chk_a("f1.n5", 91, -91, 0);
         if (i == 10) begin
            chk_a("f1.n9", 118, -49, 0);
            chk("B.n9.re", b_re, 118);
            chk("B.n9.im", b_im, -49);
         end
      end
      step(1'b0, 1'b0);
      chk_a("f1.n15", -118, 49, 1);
      chk("B.n15.re", b_re, -118);
      chk("B.n15.im", b_im, 49);
      step(1'b0, 1'b0);

      // Valid toggling 1,0,1,0: gaps hold the coefficient, indices stay consecutive.
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk_a("gap.n1", 127, 0, 0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Mid-frame restart at n=6.
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk_a("sof.n0", 127, 0, 0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Asynchronous reset mid-frame at n=10, then restart without in_sof.
      step(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      async_reset("rst");
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk_a("rst.n0", 127, 0, 0);
      step(1'b0, 1'b0);

      // Two frames back to back with no idle cycle.
      for (int i = 0; i < 32; i++) begin
         step(1'b1, i == 0);
         if (i == 17) chk_a("b2b.n16", 127, 0, 0);
      end
      step(1'b0, 1'b0);
      chk("b2b.last31", a_l, 1);
      step(1'b0, 1'b0);

      // Randomized traffic with occasional restarts and one reset.
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 19) == 0);
         step(v, s);
         if (i == 200) async_reset("rnd_rst");
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fft_twiddle_gen.md
Name: fft_twiddle_gen

Overview:
- Streaming twiddle-factor generator for the radix-2^2 SDF FFT pipeline.
- Tracks the sample index of the data stream entering a stage pair and produces the matching W_N^e as Q1.(WIDTH-1) real/imaginary words.
- Its outputs drive the b-operand (in_b_re/in_b_im) of the complex multiplier between butterfly stage pairs.
- It is the coefficient-producing end of the multiplier interface, with a fixed pipeline latency that the data path matches.

Parameters:
- WIDTH, 8: coefficient word width, signed Q1.(WIDTH-1).
- LOG2N, 6: log2 of FFT size N; must be even and >= 4.
- STAGE, 0: stage-pair index s, range 0..LOG2N/2-2. The last pair has no twiddle.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a data sample enters the stage pair this cycle.
- in_sof  input  1  qualified by in_valid: this sample is index 0 of a frame.
- tw_re  output  WIDTH  twiddle real part, signed.
- tw_im  output  WIDTH  twiddle imaginary part, signed.
- out_valid  output  1  tw_re/tw_im valid for the sample accepted 2 cycles earlier.
- out_last  output  1  with out_valid: twiddle for index N-1.

Behaviour:
- Reset, asynchronous on rst_n low:
  - index counter = 0, pipeline valids = 0.
  - tw_re = 0, tw_im = 0, out_valid = 0, out_last = 0.
  - Applies mid-frame too; the first valid after release is index 0 unless in_sof says otherwise (same result).
- Index counter n, LOG2N bits:
  - Advances only on in_valid and wraps N-1 -> 0.
  - in_valid && in_sof forces the current sample to index 0; the counter becomes 1 next cycle.
  - in_sof without in_valid is ignored.
- Exponent, with M = N/4^s and Q = M/4:
  - k = n mod M; q = k / Q; r = k mod Q.
  - q' = bit-reverse of q: 0->0, 1->2, 2->1, 3->3.
  - e = q' * r * 4^s. The maximum e < N, so no modulo is needed.
- Coefficient: W_N^e = cos(2*pi*e/N) - j*sin(2*pi*e/N).
  - Each part is scaled by 2^(WIDTH-1) and rounded to nearest, ties away from zero.
  - +1.0 saturates to 2^(WIDTH-1)-1; -1.0 = -2^(WIDTH-1) is representable.
  - The table is computed at elaboration as a constant ROM of N entries (a quarter-wave table is allowed) and must be bit-identical to this rule.
- Pipeline, latency exactly 2 cycles:
  - Cycle T: in_valid sampled, with its index.
  - T+1: registered exponent, valid and last flag.
  - T+2: registered ROM output, out_valid = 1, out_last = (index == N-1).
- Gaps: when in_valid = 0, out_valid = 0 two cycles later and tw_re/tw_im hold their last values. The counter does not advance.
- Back-to-back frames need no idle cycles. Index N-1 followed immediately by index 0 is legal.
- in_sof asserted mid-frame: the frame restarts at that sample with no error flag. Twiddles already in the pipeline are unaffected.
- Throughput: one twiddle per clock, no backpressure.

Test Plan:
- LOG2N=4, STAGE=0, WIDTH=8; reset, then 16 consecutive valids starting with in_sof -> outputs from T+2:
  - n=0..3 -> (127,0)
  - n=5 -> (91,-91)
  - n=9 -> (118,-49)
  - n=15 -> (-118,49), with out_last=1 on n=15 only.
- Same config; in_valid toggled 1,0,1,0 -> out_valid mirrors the pattern 2 cycles later; tw holds during the gaps; indices are still consecutive (second valid is n=1 -> (127,0)).
- Same config; in_sof pulsed with in_valid at n=6 -> that sample is treated as n=0 -> (127,0). The next sample is n=1, and out_last appears 15 samples later.
- rst_n dropped asynchronously mid-frame at n=10 -> outputs are 0 and out_valid is 0 immediately; after release, the next valid gives (127,0) as n=0.
- LOG2N=6, STAGE=1, WIDTH=8 (M=16, exponent scaled by 4): index 9 -> e=4 -> W64^4 = (118,-49); index 15 -> e=36 -> (-118,49).
- Two frames back-to-back with no gap -> out_last on sample 15 and sample 31; sample 16 -> (127,0).
